oled_screen_arbiter: RTL and testbench

- Shares the single 96x64 RGB565 OLED pixel stream among N_REQ screen generators (border, menu, game, etc.).
- Each generator presents a colour for the current pixel_index. The arbiter grants exactly one owner, round-robin.
- Ownership changes only at frame boundaries, with a minimum hold time and one blank frame between owners, so the display never tears.
- Sits between the pixel generators and the OLED driver's pixel_data input.

---
 rtl/oled_pkg.sv | 20 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/oled_screen_arbiter.sv | 177 +++++++++++++++++
 tb/tb_oled_screen_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared OLED definitions for the screen arbiter slice.
//   - Panel geometry of the 96x64 RGB565 OLED.
//   - Common RGB565 colour constants.
//   - Arbiter state encoding used by oled_screen_arbiter.
package oled_pkg;

   localparam int OLED_W      = 96;
   localparam int OLED_H      = 64;
   localparam int OLED_PIXELS = OLED_W * OLED_H;

   localparam logic [15:0] COLOR_BLACK = 16'h0000;
   localparam logic [15:0] COLOR_RED   = 16'hF800;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_BLANK = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
//   req     : request vector, one bit per generator
//   rr_ptr  : index where the search starts (highest priority)
//   excl    : mask of generators that may not win
//   winner  : index of the first requesting, non-excluded generator
//             found searching upward from rr_ptr, wrapping modulo N_REQ
//   found   : high when any such generator exists
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] rr_ptr,
   input  logic [N_REQ-1:0]         excl,
   output logic [$clog2(N_REQ)-1:0] winner,
   output logic                     found
);

   localparam int IDX_W = $clog2(N_REQ);

   // Walk the offsets from farthest to nearest so the candidate closest to
   // rr_ptr is the last one written and therefore wins.
   always_comb begin : p_search
      int               idx;
      logic [IDX_W-1:0] sel;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      sel    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         sel = IDX_W'(idx);
         if (req[sel] && !excl[sel]) begin
            winner = sel;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/oled_screen_arbiter.sv
// Frame-synchronous round-robin arbiter sharing one OLED pixel stream
// among N_REQ screen generators. Ownership only changes on a frame wrap,
// an owner keeps the screen at least HOLD_FRAMES frames, and a blank
// frame separates two different owners so the panel never tears.
//   clk25       : 25 MHz system clock
//   rst_n       : asynchronous active-low reset
//   pixel_index : current pixel index from the OLED driver
//   req         : level request per generator
//   color_in    : RGB565 per generator, generator i at [16*i+15:16*i]
//   color_out   : registered RGB565 to the OLED driver
//   grant       : one-hot current owner, zero in IDLE and BLANK
//   frame_tick  : one-cycle pulse when an arbitration result takes effect
//   busy        : high whenever the arbiter is not IDLE
module oled_screen_arbiter
   import oled_pkg::*;
#(
   parameter int          N_REQ         = 4,
   parameter int          HOLD_FRAMES   = 2,
   parameter int          PIXELS        = OLED_PIXELS,
   parameter logic [15:0] DEFAULT_COLOR = COLOR_BLACK
) (
   input  logic                clk25,
   input  logic                rst_n,
   input  logic [12:0]         pixel_index,
   input  logic [N_REQ-1:0]    req,
   input  logic [16*N_REQ-1:0] color_in,
   output logic [15:0]         color_out,
   output logic [N_REQ-1:0]    grant,
   output logic                frame_tick,
   output logic                busy
);

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES - 1);

   // Parameter sanity checks at elaboration time.
   generate
      if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
         $error("oled_screen_arbiter: N_REQ must be in 2..8");
      end
      if (HOLD_FRAMES < 1) begin : g_bad_hold
         $error("oled_screen_arbiter: HOLD_FRAMES must be at least 1");
      end
      if (PIXELS < 2 || PIXELS > 8192) begin : g_bad_pixels
         $error("oled_screen_arbiter: PIXELS must fit the 13-bit pixel_index");
      end
   endgenerate

   arb_state_t        state;
   logic [12:0]       prev_index;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  owner;
   logic [IDX_W-1:0]  pending;
   logic [HOLD_W-1:0] hold_cnt;

   logic              fs;
   logic [N_REQ-1:0]  excl_mask;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_found;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [N_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
      if (w == IDX_W'(N_REQ - 1)) begin
         return '0;
      end
      return w + 1'b1;
   endfunction

   // Frame start: the driver jumped back to pixel 0 from anywhere else.
   assign fs = (pixel_index == 13'd0) && (prev_index != 13'd0);

   // While OWNED the single picker looks for a challenger other than the
   // current owner; in IDLE and BLANK it is a plain round-robin search.
   always_comb begin
      excl_mask = '0;
      if (state == ST_OWNED) begin
         excl_mask[owner] = 1'b1;
      end
   end

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .excl   (excl_mask),
      .winner (pick_idx),
      .found  (pick_found)
   );

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         prev_index <= 13'd0;
         rr_ptr     <= '0;
         owner      <= '0;
         pending    <= '0;
         hold_cnt   <= '0;
         grant      <= '0;
         color_out  <= DEFAULT_COLOR;
         frame_tick <= 1'b0;
         busy       <= 1'b0;
      end else begin
         prev_index <= pixel_index;
         frame_tick <= fs;

         // Uses the grant already in force, so the new owner's colour
         // appears one cycle after frame_tick.
         color_out <= (grant != '0) ? color_in[int'(owner)*16 +: 16] : DEFAULT_COLOR;

         if (fs) begin
            case (state)
               ST_IDLE: begin
                  if (pick_found) begin
                     grant    <= onehot(pick_idx);
                     owner    <= pick_idx;
                     rr_ptr   <= next_ptr(pick_idx);
                     hold_cnt <= HOLD_INIT;
                     state    <= ST_OWNED;
                     busy     <= 1'b1;
                  end
               end

               ST_OWNED: begin
                  if (!req[owner] || hold_cnt == '0) begin
                     if (pick_found) begin
                        pending <= pick_idx;
                        grant   <= '0;
                        state   <= ST_BLANK;
                     end else if (!req[owner]) begin
                        grant <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                     // owner still requesting and unchallenged: keep it
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end

               ST_BLANK: begin
                  if (req[pending]) begin
                     grant    <= onehot(pending);
                     owner    <= pending;
                     rr_ptr   <= next_ptr(pending);
                     hold_cnt <= HOLD_INIT;
                     state    <= ST_OWNED;
                  end else if (pick_found) begin
                     grant    <= onehot(pick_idx);
                     owner    <= pick_idx;
                     rr_ptr   <= next_ptr(pick_idx);
                     hold_cnt <= HOLD_INIT;
                     state    <= ST_OWNED;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end

               default: begin
                  grant <= '0;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oled_screen_arbiter.sv
// Self-checking bench for oled_screen_arbiter with a frame-level
// behavioural reference model.
module tb_oled_screen_arbiter;

   localparam int N    = 4;
   localparam int HOLD = 2;

   logic              clk25 = 1'b0;
   logic              rst_n;
   logic [12:0]       pixel_index;
   logic [N-1:0]      req;
   logic [16*N-1:0]   color_in;
   logic [15:0]       color_out;
   logic [N-1:0]      grant;
   logic              frame_tick;
   logic              busy;

   always #20 clk25 = ~clk25;

   oled_screen_arbiter #(
      .N_REQ         (N),
      .HOLD_FRAMES   (HOLD),
      .PIXELS        (6144),
      .DEFAULT_COLOR (16'h0000)
   ) dut (
      .clk25       (clk25),
      .rst_n       (rst_n),
      .pixel_index (pixel_index),
      .req         (req),
      .color_in    (color_in),
      .color_out   (color_out),
      .grant       (grant),
      .frame_tick  (frame_tick),
      .busy        (busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: owner index (-1 = none), frames held so far,
   // blank-frame flag with the owner chosen to follow, round-robin start.
   int          m_owner;
   int          m_pending;
   int          m_ptr;
   int          m_held;
   bit          m_blank;
   logic [12:0] m_prev;
   logic [N-1:0] e_grant;
   logic [15:0]  e_color;
   logic         e_tick;
   logic         e_busy;

   // Per-frame observations gathered by the cycle driver.
   int           bad_cycles;
   int           tick_cnt;
   logic [N-1:0] last_grant;
   logic [15:0]  last_color;

   function automatic int rr_search(input logic [N-1:0] r, input int start, input int skip);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (start + k) % N;
         if (r[i] && i != skip) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_pending = 0; m_ptr = 0; m_held = 0; m_blank = 0;
      m_prev = '0; e_grant = '0; e_color = 16'h0000; e_tick = 0; e_busy = 0;
   endtask

   task automatic give(input int w);
      m_owner = w; m_held = 1; m_ptr = (w + 1) % N; m_blank = 0;
   endtask

   task automatic model_step();
      int w;
      bit start;
      if (!rst_n) begin
         model_reset();
         return;
      end
      e_color = (m_owner >= 0) ? color_in[m_owner*16 +: 16] : 16'h0000;
      start   = (pixel_index == 13'd0) && (m_prev != 13'd0);
      m_prev  = pixel_index;
      e_tick  = start;
      if (start) begin
         if (m_blank) begin
            m_blank = 0;
            if (req[m_pending]) give(m_pending);
            else begin
               w = rr_search(req, m_ptr, -1);
               if (w >= 0) give(w);
            end
         end else if (m_owner < 0) begin
            w = rr_search(req, m_ptr, -1);
            if (w >= 0) give(w);
         end else begin
            w = rr_search(req, m_ptr, m_owner);
            if (req[m_owner] && m_held < HOLD) m_held++;
            else if (w >= 0) begin
               m_pending = w; m_blank = 1; m_owner = -1;
            end else if (!req[m_owner]) m_owner = -1;
         end
      end
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      e_busy = (m_owner >= 0) || m_blank;
   endtask

   // One clk25 cycle: drive on the falling edge, sample 1 ns after the rise.
   task automatic tick(input logic [12:0] idx, input logic [N-1:0] r);
      @(negedge clk25);
      pixel_index = idx;
      req         = r;
      for (int i = 0; i < N; i++) color_in[16*i +: 16] = 16'($urandom);
      model_step();
      @(posedge clk25);
      #1;
      if (grant !== e_grant || color_out !== e_color || frame_tick !== e_tick || busy !== e_busy)
         bad_cycles++;
      last_grant = grant;
      last_color = color_out;
      if (frame_tick === 1'b1) tick_cnt++;
   endtask

   // One frame: pixel 0 held three cycles, then 1..len-1 (or random nonzero
   // indices when jumble is set); req switches from r0 to r1 at index sw.
   task automatic frame(input int len, input logic [N-1:0] r0, input logic [N-1:0] r1,
                        input int sw, input bit jumble);
      bad_cycles = 0;
      tick_cnt   = 0;
      for (int c = 0; c < 3; c++) tick(13'd0, r0);
      for (int i = 1; i < len; i++)
         tick(jumble ? 13'($urandom_range(1, 8191)) : 13'(i), (i < sw) ? r0 : r1);
   endtask

   task automatic do_reset();
      @(negedge clk25);
      rst_n = 1'b0; pixel_index = '0; req = '0;
      model_reset();
      repeat (2) @(negedge clk25);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pixel_index = '0; req = 4'b0001;
      for (int i = 0; i < N; i++) color_in[16*i +: 16] = 16'hA5A5 + 16'(i);
      model_reset();
      repeat (3) @(negedge clk25);
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
      checks++; if (color_out !== 16'h0000) begin errors++; $display("FAIL reset_color got %h want 0000", color_out); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      rst_n = 1'b1;
      frame(6144, 4'b0001, 4'b0001, 6144, 0);
      checks++; if (tick_cnt !== 0) begin errors++; $display("FAIL reset_no_fs ticks %0d want 0", tick_cnt); end
      checks++; if (last_grant !== 4'b0000) begin errors++; $display("FAIL reset_no_grant got %b want 0000", last_grant); end
      checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL reset_frame0 bad cycles %0d want 0", bad_cycles); end
      frame(16, 4'b0001, 4'b0001, 16, 0);
      checks++; if (tick_cnt !== 1) begin errors++; $display("FAIL reset_wrap ticks %0d want 1", tick_cnt); end
      checks++; if (last_grant !== 4'b0001) begin errors++; $display("FAIL reset_wrap_grant got %b want 0001", last_grant); end
      checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL reset_wrap bad cycles %0d want 0", bad_cycles); end
   endtask

   task automatic test_two_req();
      logic [N-1:0] want [4];
      want = '{4'b0001, 4'b0001, 4'b0000, 4'b0100};
      do_reset();
      frame(16, 4'b0000, 4'b0000, 16, 0);
      for (int f = 0; f < 4; f++) begin
         frame(16, 4'b0101, 4'b0101, 16, 0);
         checks++; if (last_grant !== want[f]) begin errors++; $display("FAIL two_req_f%0d grant got %b want %b", f, last_grant, want[f]); end
         checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL two_req_f%0d bad cycles %0d want 0", f, bad_cycles); end
         if (f == 2) begin
            checks++; if (last_color !== 16'h0000) begin errors++; $display("FAIL two_req_blank_color got %h want 0000", last_color); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL two_req_blank_busy got %b want 1", busy); end
         end
      end
   endtask

   task automatic test_drop();
      frame(16, 4'b0101, 4'b0010, 8, 0);
      checks++; if (last_grant !== 4'b0100) begin errors++; $display("FAIL drop_midframe grant got %b want 0100", last_grant); end
      checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL drop_midframe bad cycles %0d want 0", bad_cycles); end
      frame(16, 4'b0010, 4'b0010, 16, 0);
      checks++; if (last_grant !== 4'b0000) begin errors++; $display("FAIL drop_blank grant got %b want 0000", last_grant); end
      checks++; if (last_color !== 16'h0000) begin errors++; $display("FAIL drop_blank color got %h want 0000", last_color); end
      frame(16, 4'b0010, 4'b0010, 16, 0);
      checks++; if (last_grant !== 4'b0010) begin errors++; $display("FAIL drop_next grant got %b want 0010", last_grant); end
      checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL drop_next bad cycles %0d want 0", bad_cycles); end
   endtask

   task automatic test_all_four();
      logic [N-1:0] want [13];
      want = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
               4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
      do_reset();
      frame(12, 4'b0000, 4'b0000, 12, 0);
      for (int f = 0; f < 13; f++) begin
         frame(12, 4'b1111, 4'b1111, 12, 0);
         checks++; if (last_grant !== want[f] || bad_cycles !== 0) begin
            errors++; $display("FAIL all_four_f%0d grant got %b want %b bad cycles %0d", f, last_grant, want[f], bad_cycles);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      frame(12, 4'b0000, 4'b0000, 12, 0);
      for (int f = 0; f < 10; f++) begin
         frame(12, 4'b0010, 4'b0010, 12, 0);
         checks++; if (last_grant !== 4'b0010 || tick_cnt !== 1 || bad_cycles !== 0) begin
            errors++; $display("FAIL single_f%0d grant got %b want 0010 ticks %0d want 1 bad %0d", f, last_grant, tick_cnt, bad_cycles);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      frame(16, 4'b0000, 4'b0000, 16, 0);
      frame(16, 4'b0001, 4'b0001, 16, 0);
      for (int c = 0; c < 3; c++) tick(13'd0, 4'b0001);
      for (int i = 1; i < 6; i++) tick(13'(i), 4'b0001);
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL async_pre grant got %b want 0001", grant); end
      #5;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL async_grant got %b want 0000", grant); end
      checks++; if (color_out !== 16'h0000) begin errors++; $display("FAIL async_color got %h want 0000", color_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
      #2;
      rst_n = 1'b1;
      bad_cycles = 0;
      tick_cnt   = 0;
      for (int i = 6; i < 16; i++) tick(13'(i), 4'b0001);
      checks++; if (tick_cnt !== 0 || last_grant !== 4'b0000) begin
         errors++; $display("FAIL async_wait ticks %0d want 0 grant %b want 0000", tick_cnt, last_grant);
      end
      tick(13'd0, 4'b0001);
      checks++; if (grant !== 4'b0001 || frame_tick !== 1'b1) begin
         errors++; $display("FAIL async_regrant grant %b want 0001 tick %b want 1", grant, frame_tick);
      end
      tick(13'd0, 4'b0001);
      checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL async_after bad cycles %0d want 0", bad_cycles); end
   endtask

   task automatic test_random();
      int           len;
      int           sw;
      logic [N-1:0] r0;
      logic [N-1:0] r1;
      do_reset();
      frame(10, 4'b0000, 4'b0000, 10, 0);
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(4, 20);
         sw  = $urandom_range(1, len);
         r0  = N'($urandom);
         r1  = ($urandom_range(0, 2) == 0) ? N'($urandom) : r0;
         frame(len, r0, r1, sw, ($urandom_range(0, 3) == 0));
         checks++; if (bad_cycles !== 0) begin
            errors++; $display("FAIL random_f%0d bad cycles %0d want 0 (req %b/%b)", f, bad_cycles, r0, r1);
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      pixel_index = '0;
      req         = '0;
      color_in    = '0;
      bad_cycles  = 0;
      tick_cnt    = 0;
      last_grant  = '0;
      last_color  = '0;
      model_reset();
      test_reset();
      test_two_req();
      test_drop();
      test_all_four();
      test_single();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
